pcler_counter: RTL

Parametrised loadable up/down counter with a programmable auto-reload value, one-shot mode and a cascadable terminal-count output. It is the sequential successor to the team's fixed 8-bit load/clear/enable counter next-state logic, and it holds its own state register. It sits in timer and prescaler chains, where wide counters are built by feeding one stage's `tc` into the next stage's `en`.

---
 rtl/pcler_counter.sv | 112 +++++++++++
 1 files changed

// File: rtl/pcler_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pcler_counter
//  Purpose  : Parametrised loadable up/down counter with a programmable
//             auto-reload register, one-shot stop mode and a combinational
//             terminal-count output for building wide counters by cascading
//             (stage N tc drives stage N+1 en).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       counter / reload width in bits (2..32)
//    RELOAD_RST  reset value of the reload register
//  Ports
//    clk      in   rising-edge clock
//    rst_n    in   asynchronous active-low reset
//    clr      in   synchronous clear of count and done (highest priority)
//    ld       in   synchronous load of d into count, clears done
//    d        in   parallel load data
//    rl_we    in   reload register write enable
//    rl_d     in   reload register write data
//    en       in   count enable / cascade input
//    up       in   1 = count up (terminal all ones), 0 = down (terminal 0)
//    oneshot  in   1 = stop at terminal instead of reloading
//    count    out  current count register
//    tc       out  combinational terminal count for cascading
//    wrap     out  registered one-cycle pulse: a reload or stop occurred
//    done     out  sticky one-shot-reached-terminal flag
// ============================================================================
module pcler_counter #(
  parameter int unsigned        WIDTH      = 8,
  parameter logic [WIDTH-1:0]   RELOAD_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             rl_we,
  input  logic [WIDTH-1:0] rl_d,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] term_val;
  logic             at_term;

  logic [WIDTH-1:0] count_nxt;
  logic             done_nxt;
  logic             wrap_nxt;

  // Terminal value follows the current direction with no register stage.
  assign term_val = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign at_term  = (count == term_val);

  // Suppressed by ld/clr so an upper cascade stage never advances on a cycle
  // where this stage is being overwritten rather than wrapping.
  assign tc = en & at_term & ~ld & ~clr;

  always_comb begin
    count_nxt = count;
    done_nxt  = done;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
      done_nxt  = 1'b0;
    end else if (ld) begin
      count_nxt = d;
      done_nxt  = 1'b0;
    end else if (en) begin
      if (done) begin
        // one-shot already finished: hold everything, no further wrap pulse
        count_nxt = count;
      end else if (at_term) begin
        wrap_nxt = 1'b1;
        if (oneshot) begin
          done_nxt = 1'b1;
        end else begin
          // reload register is read before any same-cycle write lands
          count_nxt = reload;
        end
      end else if (up) begin
        count_nxt = count + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_nxt = count - {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      reload <= RELOAD_RST;
      wrap   <= 1'b0;
      done   <= 1'b0;
    end else begin
      count <= count_nxt;
      done  <= done_nxt;
      wrap  <= wrap_nxt;
      if (rl_we) begin
        reload <= rl_d;
      end
    end
  end

endmodule
`default_nettype wire
